// File: rtl/vga_time_feed_pkg.sv
// rtl/vga_time_feed_pkg.sv - shared address map, CTRL fields and BCD helper for vga_time_feed
package vga_time_feed_pkg;

    localparam logic [7:0] ADDR_HOUR0  = 8'h00;
    localparam logic [7:0] ADDR_HOUR1  = 8'h01;
    localparam logic [7:0] ADDR_HOUR2  = 8'h02;
    localparam logic [7:0] ADDR_DATE0  = 8'h03;
    localparam logic [7:0] ADDR_DATE1  = 8'h04;
    localparam logic [7:0] ADDR_DATE2  = 8'h05;
    localparam logic [7:0] ADDR_TIMER0 = 8'h06;
    localparam logic [7:0] ADDR_TIMER1 = 8'h07;
    localparam logic [7:0] ADDR_TIMER2 = 8'h08;
    localparam logic [7:0] ADDR_CTRL   = 8'h09;
    localparam logic [7:0] ADDR_COMMIT = 8'h0A;
    localparam logic [7:0] ADDR_STATUS = 8'h0B;

    localparam int CTRL_PROG    = 0;
    localparam int CTRL_RUN     = 1;
    localparam int CTRL_CLR     = 2;
    localparam int CTRL_DIR_LSB = 4;

    localparam logic [7:0] BCD_ZERO = 8'h00;

    typedef struct packed {
        logic [7:0] val;
        logic       borrow;
    } bcd_dec_t;

    // Decrement a two-digit BCD byte; when it underflows from 00 the tens
    // digit reloads with tens_wrap and a borrow is passed to the next byte.
    function automatic bcd_dec_t bcd_dec(input logic [7:0] v, input logic [3:0] tens_wrap);
        bcd_dec_t r;
        r.val    = v;
        r.borrow = 1'b0;
        if (v[3:0] == 4'd0) begin
            r.val[3:0] = 4'd9;
            if (v[7:4] == 4'd0) begin
                r.val[7:4] = tens_wrap;
                r.borrow   = 1'b1;
            end else begin
                r.val[7:4] = v[7:4] - 4'd1;
            end
        end else begin
            r.val[3:0] = v[3:0] - 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_time_feed_bcd_timer_down.sv
// rtl/vga_time_feed_bcd_timer_down.sv - hh:mm:ss BCD countdown with per-byte load
module bcd_timer_down
    import vga_time_feed_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] load_en,
    input  logic [7:0] load_data,
    input  logic       tick,
    input  logic       run,
    output logic [7:0] sec,
    output logic [7:0] min,
    output logic [7:0] hr,
    output logic       zero,
    output logic       done
);

    logic [7:0] sec_q, sec_d;
    logic [7:0] min_q, min_d;
    logic [7:0] hr_q,  hr_d;
    bcd_dec_t   dec_s, dec_m, dec_h;
    logic       step;

    // Next-value logic: any byte load suppresses the tick for the whole counter.
    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        zero  = (sec_q == BCD_ZERO) && (min_q == BCD_ZERO) && (hr_q == BCD_ZERO);
        dec_s = bcd_dec(sec_q, 4'd5);
        dec_m = bcd_dec(min_q, 4'd5);
        dec_h = bcd_dec(hr_q, 4'd0);
        step  = tick && run && !zero && (load_en == 3'b000);
        if (load_en != 3'b000) begin
            if (load_en[0]) sec_d = load_data;
            if (load_en[1]) min_d = load_data;
            if (load_en[2]) hr_d  = load_data;
        end else if (step) begin
            sec_d = dec_s.val;
            if (dec_s.borrow) begin
                min_d = dec_m.val;
                if (dec_m.borrow) begin
                    hr_d = dec_h.val;
                end
            end
        end
        done = step && (sec_d == BCD_ZERO) && (min_d == BCD_ZERO) && (hr_d == BCD_ZERO);
    end

    // Counter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sec_q <= BCD_ZERO;
            min_q <= BCD_ZERO;
            hr_q  <= BCD_ZERO;
        end else begin
            sec_q <= sec_d;
            min_q <= min_d;
            hr_q  <= hr_d;
        end
    end

    assign sec = sec_q;
    assign min = min_q;
    assign hr  = hr_q;

endmodule

// File: rtl/vga_time_feed.sv
// rtl/vga_time_feed.sv - PicoBlaze register file feeding tear-free clock/date/timer bytes to the VGA top
module vga_time_feed
    import vga_time_feed_pkg::*;
#(
    parameter bit VSYNC_ACT_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] port_id,
    input  logic [7:0] out_port,
    input  logic       write_strobe,
    output logic [7:0] in_port,
    input  logic       tick_1hz,
    input  logic       vsync,
    output logic [7:0] hour_in1,
    output logic [7:0] hour_in2,
    output logic [7:0] hour_in3,
    output logic [7:0] fecha_in1,
    output logic [7:0] fecha_in2,
    output logic [7:0] fecha_in3,
    output logic [7:0] timer_in1,
    output logic [7:0] timer_in2,
    output logic [7:0] timer_in3,
    output logic       programar_on,
    output logic [3:0] direccion_actual_pantalla,
    output logic       activar_alarma
);

    // Idle level of vsync; the edge detector resets here so release of reset
    // does not fake a frame start while vsync sits idle.
    localparam logic VSYNC_IDLE = VSYNC_ACT_LOW;

    logic            vsync_q, vsync_d;
    logic            fs_q, fs_d;
    logic [2:0][7:0] hour_sh_q, hour_sh_d;
    logic [2:0][7:0] date_sh_q, date_sh_d;
    logic            prog_sh_q, prog_sh_d;
    logic [3:0]      dir_sh_q, dir_sh_d;
    logic [2:0][7:0] hour_disp_q, hour_disp_d;
    logic [2:0][7:0] date_disp_q, date_disp_d;
    logic [2:0][7:0] timer_disp_q, timer_disp_d;
    logic            prog_disp_q, prog_disp_d;
    logic [3:0]      dir_disp_q, dir_disp_d;
    logic            run_q, run_d;
    logic            alarm_q, alarm_d;
    logic            pend_q, pend_d;

    logic [2:0]      tmr_load;
    logic [7:0]      tmr_sec, tmr_min, tmr_hr;
    logic            tmr_zero, tmr_done;
    logic            commit_wr;

    // Timer byte writes go straight to the live counter.
    always_comb begin
        tmr_load    = 3'b000;
        tmr_load[0] = write_strobe && (port_id == ADDR_TIMER0);
        tmr_load[1] = write_strobe && (port_id == ADDR_TIMER1);
        tmr_load[2] = write_strobe && (port_id == ADDR_TIMER2);
        commit_wr   = write_strobe && (port_id == ADDR_COMMIT);
    end

    bcd_timer_down u_timer (
        .clk       (clk),
        .rst_n     (reset),
        .load_en   (tmr_load),
        .load_data (out_port),
        .tick      (tick_1hz),
        .run       (run_q),
        .sec       (tmr_sec),
        .min       (tmr_min),
        .hr        (tmr_hr),
        .zero      (tmr_zero),
        .done      (tmr_done)
    );

    // Frame-start detector: registered vsync compared against the live pin.
    always_comb begin
        vsync_d = vsync;
        if (VSYNC_ACT_LOW) fs_d = vsync_q && !vsync;
        else               fs_d = !vsync_q && vsync;
    end

    // Register file, run/alarm control and frame-synchronous display update.
    always_comb begin
        hour_sh_d    = hour_sh_q;
        date_sh_d    = date_sh_q;
        prog_sh_d    = prog_sh_q;
        dir_sh_d     = dir_sh_q;
        hour_disp_d  = hour_disp_q;
        date_disp_d  = date_disp_q;
        timer_disp_d = timer_disp_q;
        prog_disp_d  = prog_disp_q;
        dir_disp_d   = dir_disp_q;
        run_d        = run_q;
        alarm_d      = alarm_q;
        pend_d       = pend_q;

        if (write_strobe) begin
            case (port_id)
                ADDR_HOUR0: hour_sh_d[0] = out_port;
                ADDR_HOUR1: hour_sh_d[1] = out_port;
                ADDR_HOUR2: hour_sh_d[2] = out_port;
                ADDR_DATE0: date_sh_d[0] = out_port;
                ADDR_DATE1: date_sh_d[1] = out_port;
                ADDR_DATE2: date_sh_d[2] = out_port;
                ADDR_CTRL: begin
                    run_d     = out_port[CTRL_RUN];
                    prog_sh_d = out_port[CTRL_PROG];
                    dir_sh_d  = out_port[CTRL_DIR_LSB +: 4];
                    if (out_port[CTRL_CLR]) alarm_d = 1'b0;
                end
                default: ;
            endcase
        end

        // Countdown reaching zero stops the timer and wins over a clear.
        if (tmr_done) begin
            run_d   = 1'b0;
            alarm_d = 1'b1;
        end

        if (fs_q) begin
            timer_disp_d = {tmr_hr, tmr_min, tmr_sec};
            if (pend_q) begin
                hour_disp_d = hour_sh_q;
                date_disp_d = date_sh_q;
                prog_disp_d = prog_sh_q;
                dir_disp_d  = dir_sh_q;
                pend_d      = 1'b0;
            end
        end

        // A commit landing on the frame-start cycle waits for the next frame.
        if (commit_wr) pend_d = 1'b1;
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vsync_q      <= VSYNC_IDLE;
            fs_q         <= 1'b0;
            hour_sh_q    <= '0;
            date_sh_q    <= '0;
            prog_sh_q    <= 1'b0;
            dir_sh_q     <= 4'd0;
            hour_disp_q  <= '0;
            date_disp_q  <= '0;
            timer_disp_q <= '0;
            prog_disp_q  <= 1'b0;
            dir_disp_q   <= 4'd0;
            run_q        <= 1'b0;
            alarm_q      <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            vsync_q      <= vsync_d;
            fs_q         <= fs_d;
            hour_sh_q    <= hour_sh_d;
            date_sh_q    <= date_sh_d;
            prog_sh_q    <= prog_sh_d;
            dir_sh_q     <= dir_sh_d;
            hour_disp_q  <= hour_disp_d;
            date_disp_q  <= date_disp_d;
            timer_disp_q <= timer_disp_d;
            prog_disp_q  <= prog_disp_d;
            dir_disp_q   <= dir_disp_d;
            run_q        <= run_d;
            alarm_q      <= alarm_d;
            pend_q       <= pend_d;
        end
    end

    // PicoBlaze read mux.
    always_comb begin
        in_port = 8'h00;
        case (port_id)
            ADDR_HOUR0:  in_port = hour_sh_q[0];
            ADDR_HOUR1:  in_port = hour_sh_q[1];
            ADDR_HOUR2:  in_port = hour_sh_q[2];
            ADDR_DATE0:  in_port = date_sh_q[0];
            ADDR_DATE1:  in_port = date_sh_q[1];
            ADDR_DATE2:  in_port = date_sh_q[2];
            ADDR_TIMER0: in_port = tmr_sec;
            ADDR_TIMER1: in_port = tmr_min;
            ADDR_TIMER2: in_port = tmr_hr;
            ADDR_CTRL:   in_port = {dir_sh_q, 2'b00, run_q, prog_sh_q};
            ADDR_STATUS: in_port = {6'b0, pend_q, alarm_q};
            default:     in_port = 8'h00;
        endcase
    end

    assign hour_in1                  = hour_disp_q[0];
    assign hour_in2                  = hour_disp_q[1];
    assign hour_in3                  = hour_disp_q[2];
    assign fecha_in1                 = date_disp_q[0];
    assign fecha_in2                 = date_disp_q[1];
    assign fecha_in3                 = date_disp_q[2];
    assign timer_in1                 = timer_disp_q[0];
    assign timer_in2                 = timer_disp_q[1];
    assign timer_in3                 = timer_disp_q[2];
    assign programar_on              = prog_disp_q;
    assign direccion_actual_pantalla = dir_disp_q;
    assign activar_alarma            = alarm_q;

endmodule

// File: tb/tb_vga_time_feed.sv
// tb/tb_vga_time_feed.sv - directed bench for vga_time_feed
module tb_vga_time_feed;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       write_strobe;
    logic [7:0] in_port;
    logic       tick_1hz;
    logic       vsync;
    logic [7:0] hour_in1, hour_in2, hour_in3;
    logic [7:0] fecha_in1, fecha_in2, fecha_in3;
    logic [7:0] timer_in1, timer_in2, timer_in3;
    logic       programar_on;
    logic [3:0] direccion_actual_pantalla;
    logic       activar_alarma;

    int vectors = 0;
    int errors  = 0;

    vga_time_feed #(.VSYNC_ACT_LOW(1'b1)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .port_id                   (port_id),
        .out_port                  (out_port),
        .write_strobe              (write_strobe),
        .in_port                   (in_port),
        .tick_1hz                  (tick_1hz),
        .vsync                     (vsync),
        .hour_in1                  (hour_in1),
        .hour_in2                  (hour_in2),
        .hour_in3                  (hour_in3),
        .fecha_in1                 (fecha_in1),
        .fecha_in2                 (fecha_in2),
        .fecha_in3                 (fecha_in3),
        .timer_in1                 (timer_in1),
        .timer_in2                 (timer_in2),
        .timer_in3                 (timer_in3),
        .programar_on              (programar_on),
        .direccion_actual_pantalla (direccion_actual_pantalla),
        .activar_alarma            (activar_alarma)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        port_id = a;
        #1;
        chk(tag, in_port, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        port_id = a;
        out_port = d;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
        tick_1hz = 1'b1;
        @(negedge clk);
        tick_1hz = 1'b0;
    endtask

    // vsync falls; display is sampled two rising edges later.
    task automatic frame();
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vsync = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        port_id = 8'h00;
        out_port = 8'h00;
        write_strobe = 1'b0;
        tick_1hz = 1'b0;
        vsync = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_hour_in1", hour_in1, 8'h00);
        chk("rst_alarm", {7'b0, activar_alarma}, 8'h00);
        rd("rst_status", 8'h0B, 8'h00);
        reset = 1'b1;

        // Populate display, then reset asynchronously mid-frame.
        wr(8'h00, 8'h45);
        wr(8'h09, 8'hA3);
        wr(8'h06, 8'h09);
        wr(8'h0A, 8'h00);
        frame();
        chk("pre_hour_in1", hour_in1, 8'h45);
        chk("pre_prog", {7'b0, programar_on}, 8'h01);
        chk("pre_timer_in1", timer_in1, 8'h09);
        @(negedge clk);
        vsync = 1'b0;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_hour_in1", hour_in1, 8'h00);
        chk("arst_timer_in1", timer_in1, 8'h00);
        chk("arst_prog", {7'b0, programar_on}, 8'h00);
        chk("arst_dir", {4'b0, direccion_actual_pantalla}, 8'h00);
        rd("arst_status", 8'h0B, 8'h00);
        rd("arst_live_sec", 8'h06, 8'h00);
        vsync = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        frame();
        chk("post_rst_fs_hour", hour_in1, 8'h00);

        // Shadow writes held back until a committed frame start.
        wr(8'h00, 8'h45);
        wr(8'h02, 8'h12);
        wr(8'h0A, 8'h00);
        repeat (3) @(negedge clk);
        chk("hold_hour_in1", hour_in1, 8'h00);
        rd("pend_status", 8'h0B, 8'h02);
        rd("shadow_rd", 8'h00, 8'h45);
        frame();
        chk("commit_hour_in1", hour_in1, 8'h45);
        chk("commit_hour_in2", hour_in2, 8'h00);
        chk("commit_hour_in3", hour_in3, 8'h12);
        rd("commit_status", 8'h0B, 8'h00);

        // Countdown with minute borrow.
        wr(8'h07, 8'h01);
        wr(8'h09, 8'h02);
        tick();
        rd("dec_sec", 8'h06, 8'h59);
        rd("dec_min", 8'h07, 8'h00);
        frame();
        chk("fs_timer_in1", timer_in1, 8'h59);
        chk("fs_timer_in2", timer_in2, 8'h00);
        chk("fs_no_commit_hour", hour_in1, 8'h45);

        // Countdown to zero raises the alarm and stops the timer.
        wr(8'h06, 8'h01);
        wr(8'h07, 8'h00);
        tick();
        rd("zero_sec", 8'h06, 8'h00);
        chk("alarm_set", {7'b0, activar_alarma}, 8'h01);
        rd("alarm_status", 8'h0B, 8'h01);
        tick();
        rd("zero_hold_sec", 8'h06, 8'h00);
        chk("alarm_sticky", {7'b0, activar_alarma}, 8'h01);
        wr(8'h09, 8'h04);
        chk("alarm_clr", {7'b0, activar_alarma}, 8'h00);
        wr(8'h06, 8'h05);
        tick();
        rd("stopped_sec", 8'h06, 8'h05);

        // Commit landing on the frame-start cycle defers to the next frame.
        wr(8'h00, 8'h33);
        @(negedge clk);
        vsync = 1'b0;
        @(negedge clk);
        port_id = 8'h0A;
        write_strobe = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        vsync = 1'b1;
        chk("coinc_hour_in1", hour_in1, 8'h45);
        rd("coinc_status", 8'h0B, 8'h02);
        frame();
        chk("next_hour_in1", hour_in1, 8'h33);
        rd("next_status", 8'h0B, 8'h00);

        // Date, program flag and screen select committed together.
        wr(8'h03, 8'h15);
        wr(8'h04, 8'h06);
        wr(8'h05, 8'h24);
        wr(8'h09, 8'hA1);
        rd("date_shadow", 8'h04, 8'h06);
        wr(8'h0A, 8'h00);
        frame();
        chk("fecha_in1", fecha_in1, 8'h15);
        chk("fecha_in2", fecha_in2, 8'h06);
        chk("fecha_in3", fecha_in3, 8'h24);
        chk("programar_on", {7'b0, programar_on}, 8'h01);
        chk("dir", {4'b0, direccion_actual_pantalla}, 8'h0A);
        rd("unmapped_rd", 8'h20, 8'h00);

        // Timer write coincident with a tick drops the tick.
        wr(8'h08, 8'h10);
        wr(8'h07, 8'h00);
        wr(8'h06, 8'h00);
        wr(8'h09, 8'h02);
        @(negedge clk);
        port_id = 8'h06;
        out_port = 8'h30;
        write_strobe = 1'b1;
        tick_1hz = 1'b1;
        @(negedge clk);
        write_strobe = 1'b0;
        tick_1hz = 1'b0;
        rd("wr_tick_sec", 8'h06, 8'h30);
        rd("wr_tick_min", 8'h07, 8'h00);
        rd("wr_tick_hr", 8'h08, 8'h10);
        tick();
        rd("after_sec", 8'h06, 8'h29);
        frame();
        chk("fin_timer_in1", timer_in1, 8'h29);
        chk("fin_timer_in3", timer_in3, 8'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
